// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Callers zero-extend narrower pointers into 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down; the MSB passes through unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer controller of an asynchronous FIFO: read pointer, empty,
// almost-empty, occupancy count and underflow reporting in the read domain.
module rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   w_ptr,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rcount,
    output logic                  runderflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("rd_ptr_ctrl: SYNC_STAGES must be in 2..4");
    end

    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] count_next;
    logic          rd_ok;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst),
        .d     (w_ptr),
        .q     (wq_gray)
    );

    // Next pointer and next occupancy; a read and an arriving write fold into one update.
    always_comb begin
        rd_ok      = rinc & ~rempty;
        bin_next   = r_bin + {{ADDR_WIDTH{1'b0}}, rd_ok};
        gray_next  = PW'(bin2gray(32'(bin_next)));
        wq_bin     = PW'(gray2bin(32'(wq_gray)));
        count_next = wq_bin - bin_next;
    end

    assign ren   = rd_ok;
    assign raddr = r_bin[ADDR_WIDTH-1:0];

    // Pointer and status registers; empty is judged on the post-read pointer.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_bin      <= '0;
            r_ptr      <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rcount     <= '0;
            runderflow <= 1'b0;
        end else begin
            r_bin      <= bin_next;
            r_ptr      <= gray_next;
            rempty     <= (gray_next == wq_gray);
            raempty    <= (count_next <= aempty_thresh);
            rcount     <= count_next;
            runderflow <= rinc & rempty;
        end
    end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed bench for rd_ptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2, aempty_thresh=2).
module tb_rd_ptr_ctrl;

    logic       r_clk;
    logic       r_rst;
    logic       rinc;
    logic [4:0] w_ptr;
    logic [4:0] aempty_thresh;
    logic [4:0] r_ptr;
    logic [3:0] raddr;
    logic       ren;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
    logic       runderflow;

    int checks = 0;
    int errors = 0;

    rd_ptr_ctrl #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .r_clk         (r_clk),
        .r_rst         (r_rst),
        .rinc          (rinc),
        .w_ptr         (w_ptr),
        .aempty_thresh (aempty_thresh),
        .r_ptr         (r_ptr),
        .raddr         (raddr),
        .ren           (ren),
        .rempty        (rempty),
        .raempty       (raempty),
        .rcount        (rcount),
        .runderflow    (runderflow)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rinc;
        logic [4:0] w_ptr;
        logic       rempty;
        logic       raempty;
        logic [4:0] rcount;
        logic [3:0] raddr;
        logic [4:0] r_ptr;
        logic       runderflow;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One active edge, then return to the sampling point on the falling edge.
    task automatic step();
        @(posedge r_clk);
        @(negedge r_clk);
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    function automatic int ones(input logic [4:0] v);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(v[i]);
        return n;
    endfunction

    int         wb;
    int         rb;
    logic [4:0] prev_ptr;

    initial begin
        // rinc, w_ptr, rempty, raempty, rcount, raddr, r_ptr, runderflow
        vecs[0]  = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b1};
        vecs[1]  = '{1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b0};
        vecs[3]  = '{1'b0, 5'd7, 1'b0, 1'b0, 5'd5, 4'd0, 5'd0, 1'b0};
        vecs[4]  = '{1'b1, 5'd7, 1'b0, 1'b0, 5'd4, 4'd1, 5'd1, 1'b0};
        vecs[5]  = '{1'b1, 5'd7, 1'b0, 1'b0, 5'd3, 4'd2, 5'd3, 1'b0};
        vecs[6]  = '{1'b1, 5'd7, 1'b0, 1'b1, 5'd2, 4'd3, 5'd2, 1'b0};
        vecs[7]  = '{1'b1, 5'd7, 1'b0, 1'b1, 5'd1, 4'd4, 5'd6, 1'b0};
        vecs[8]  = '{1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 4'd5, 5'd7, 1'b0};
        vecs[9]  = '{1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 4'd5, 5'd7, 1'b1};
        vecs[10] = '{1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 4'd5, 5'd7, 1'b0};
        vecs[11] = '{1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 4'd5, 5'd7, 1'b0};
        vecs[12] = '{1'b0, 5'd5, 1'b0, 1'b1, 5'd1, 4'd5, 5'd7, 1'b0};
        vecs[13] = '{1'b0, 5'd4, 1'b0, 1'b1, 5'd1, 4'd5, 5'd7, 1'b0};
        vecs[14] = '{1'b0, 5'd4, 1'b0, 1'b1, 5'd1, 4'd5, 5'd7, 1'b0};
        vecs[15] = '{1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 4'd6, 5'd5, 1'b0};
        vecs[16] = '{1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 4'd7, 5'd4, 1'b0};

        r_rst         = 1'b0;
        rinc          = 1'b0;
        w_ptr         = 5'd0;
        aempty_thresh = 5'd2;
        step();
        step();
        r_rst = 1'b1;

        check("reset rempty",  int'(rempty),  1);
        check("reset raempty", int'(raempty), 1);
        check("reset rcount",  int'(rcount),  0);
        check("reset r_ptr",   int'(r_ptr),   0);

        // Underflow after reset, fill to 5, drain, late write, read concurrent with write.
        for (int i = 0; i < 17; i++) begin
            rinc  = vecs[i].rinc;
            w_ptr = vecs[i].w_ptr;
            step();
            check($sformatf("vec%0d rempty", i),     int'(rempty),     int'(vecs[i].rempty));
            check($sformatf("vec%0d raempty", i),    int'(raempty),    int'(vecs[i].raempty));
            check($sformatf("vec%0d rcount", i),     int'(rcount),     int'(vecs[i].rcount));
            check($sformatf("vec%0d raddr", i),      int'(raddr),      int'(vecs[i].raddr));
            check($sformatf("vec%0d r_ptr", i),      int'(r_ptr),      int'(vecs[i].r_ptr));
            check($sformatf("vec%0d runderflow", i), int'(runderflow), int'(vecs[i].runderflow));
        end
        rinc = 1'b0;

        // Wrap-around: 40 more words from pointer 7 crosses 31 -> 0.
        wb       = 7;
        rb       = 7;
        prev_ptr = r_ptr;
        for (int r = 0; r < 5; r++) begin
            wb    = wb + 8;
            w_ptr = gray5(wb);
            rinc  = 1'b0;
            repeat (3) step();
            check($sformatf("wrap%0d rcount", r), int'(rcount), 8);
            check($sformatf("wrap%0d rempty", r), int'(rempty), 0);
            for (int j = 0; j < 8; j++) begin
                rinc = 1'b1;
                #1;
                check($sformatf("wrap%0d.%0d ren", r, j), int'(ren), 1);
                step();
                rb = rb + 1;
                check($sformatf("wrap%0d.%0d r_ptr", r, j), int'(r_ptr), int'(gray5(rb)));
                check($sformatf("wrap%0d.%0d gray step", r, j), ones(r_ptr ^ prev_ptr), 1);
                check($sformatf("wrap%0d.%0d rcount", r, j), int'(rcount), 7 - j);
                check($sformatf("wrap%0d.%0d rcount<=16", r, j), int'(rcount <= 5'd16), 1);
                prev_ptr = r_ptr;
            end
            rinc = 1'b0;
        end
        check("wrap final rempty", int'(rempty), 1);

        // Full depth from a fresh reset.
        r_rst = 1'b0;
        #1;
        r_rst = 1'b1;
        w_ptr = gray5(16);
        rinc  = 1'b0;
        repeat (3) step();
        check("full rcount",  int'(rcount),  16);
        check("full rempty",  int'(rempty),  0);
        check("full raempty", int'(raempty), 0);
        check("full r_ptr",   int'(r_ptr),   0);

        rinc = 1'b1;
        repeat (9) step();
        rinc = 1'b0;
        check("pre-reset rcount", int'(rcount), 7);
        check("pre-reset raddr",  int'(raddr),  9);

        // Asynchronous reset between clock edges.
        #2;
        r_rst = 1'b0;
        #1;
        check("async rempty",     int'(rempty),     1);
        check("async raempty",    int'(raempty),    1);
        check("async rcount",     int'(rcount),     0);
        check("async r_ptr",      int'(r_ptr),      0);
        check("async raddr",      int'(raddr),      0);
        check("async runderflow", int'(runderflow), 0);
        @(negedge r_clk);
        r_rst = 1'b1;
        rinc  = 1'b1;
        step();
        check("post-reset underflow", int'(runderflow), 1);
        check("post-reset raddr",     int'(raddr),      0);
        check("post-reset rempty",    int'(rempty),     1);
        rinc = 1'b0;
        repeat (2) step();
        check("post-reset resync rcount", int'(rcount), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_ptr_ctrl.md
RD_PTR_CTRL -- requirements
Module: rd_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width; FIFO depth = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronising w_ptr; legal range 2..4.
REQ-003 SHALL have port r_clk  input  1  read-domain clock; the block's only clock.
REQ-004 SHALL have port r_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rinc  input  1  read request.
REQ-006 SHALL have port w_ptr  input  ADDR_WIDTH+1  Gray write pointer, unsynchronised, from the write domain.
REQ-007 SHALL have port aempty_thresh  input  ADDR_WIDTH+1  almost-empty threshold in words, quasi-static.
REQ-008 SHALL have port r_ptr  output  ADDR_WIDTH+1  registered Gray read pointer, to the write domain.
REQ-009 SHALL have port raddr  output  ADDR_WIDTH  memory read address = low bits of binary read pointer.
REQ-010 SHALL have port ren  output  1  memory read enable = rinc & ~rempty, combinational.
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port raempty  output  1  registered almost-empty flag.
REQ-013 SHALL have port rcount  output  ADDR_WIDTH+1  registered count of readable words, 0..2^ADDR_WIDTH.
REQ-014 SHALL have port runderflow  output  1  registered one-cycle pulse flagging a rejected read.

Function
REQ-015 SHALL synchronise w_ptr through SYNC_STAGES r_clk flops to give wq_gray; no logic is placed between stages.
REQ-016 SHALL compute bin_next = r_bin + (rinc & ~rempty), modulo 2^(ADDR_WIDTH+1), with natural wrap-around.
REQ-017 SHALL compute gray_next = bin_next ^ (bin_next >> 1) over all ADDR_WIDTH+1 bits, and register r_bin <= bin_next and r_ptr <= gray_next on every edge.
REQ-018 SHALL register rempty <= (gray_next == wq_gray), so the read that consumes the last word asserts rempty on the same edge.
REQ-019 SHALL convert wq_gray to binary wq_bin by the prefix-XOR rule, with MSB unchanged.
REQ-020 SHALL register rcount <= (wq_bin - bin_next) modulo 2^(ADDR_WIDTH+1).
REQ-021 SHALL register raempty <= (next rcount <= aempty_thresh); with aempty_thresh = 0, raempty equals rempty.
REQ-022 SHALL register runderflow <= rinc & rempty; the pointer does not move on an underflow.
REQ-023 SHALL reflect a w_ptr change in rempty/rcount no later than SYNC_STAGES+1 r_clk edges after it is stable.
REQ-024 SHALL never let r_bin pass wq_bin; a rinc held while empty is ignored every cycle.
REQ-025 SHALL, on a read concurrent with a write arriving through the synchroniser, apply both in one update: rcount stays the same and rempty stays deasserted.

Reset
REQ-026 SHALL, while r_rst=0, force r_bin=0, r_ptr=0, all synchroniser flops=0, rcount=0, rempty=1, raempty=1 and runderflow=0, independent of r_clk.
REQ-027 SHALL let reset assert asynchronously mid-transfer and discard all in-flight state; the first rinc after release is rejected as an underflow unless data has been synchronised.

Structure
REQ-028 SHALL take the defaults ADDR_WIDTH and SYNC_STAGES and the bin2gray/gray2bin functions from the shared package fifo_pkg, which the write-side controller also uses.
REQ-029 SHALL instantiate the synchroniser as the sub-module ptr_sync (parameters WIDTH and STAGES, async active-low reset).

Verification
REQ-030 SHALL cover reset: release with w_ptr=0 -> rempty=1, raempty=1, rcount=0, r_ptr=0; rinc=1 -> runderflow pulses, raddr stays 0.
REQ-031 SHALL cover the fill/drain path (ADDR_WIDTH=4, SYNC_STAGES=2, aempty_thresh=2): w_ptr set to gray(5)=5'b00111 -> after 3 edges rempty=0, rcount=5, raempty=0; five reads -> rcount 4,3,2,1,0, raempty asserts at rcount=2, rempty asserts on the fifth read edge.
REQ-032 SHALL cover wrap-around: cycle 40 words through -> r_ptr follows the Gray sequence across 31->0 with one bit changing per step, and rcount never exceeds 16.
REQ-033 SHALL cover the full-depth case: w_ptr=gray(16) with r_bin=0 -> rcount=16 and rempty=0.
REQ-034 SHALL cover simultaneous events: a read while w_ptr advances by one at steady state -> rcount unchanged and rempty stays 0.
REQ-035 SHALL cover reset mid-operation: assert r_rst with rcount=7 -> all outputs return to their reset values immediately, without an r_clk edge.
